// File: rtl/sfifo_pkg.sv
// rtl/sfifo_pkg.sv - shared constants and elaboration helpers for sfifo_flex
package sfifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int sfifo_addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Legal configuration: power-of-two depth >= 2, thresholds inside the count range.
  function automatic bit sfifo_cfg_ok(input int width, input int depth, input int fwft,
                                      input int af_thresh, input int ae_thresh);
    bit ok;
    ok = (width >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0);
    ok = ok && (fwft == FIFO_STD || fwft == FIFO_FWFT);
    ok = ok && (af_thresh >= 1) && (af_thresh <= depth);
    ok = ok && (ae_thresh >= 0) && (ae_thresh <= depth - 1);
    return ok;
  endfunction

endpackage

// File: rtl/sfifo_mem.sv
// rtl/sfifo_mem.sv - WIDTH x DEPTH register array, sync write, async read
module sfifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sfifo_flex.sv
// rtl/sfifo_flex.sv - parametrised synchronous FIFO with FWFT mode and level flags
module sfifo_flex
  import sfifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int FWFT      = FIFO_STD,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   w_en,
  input  logic [WIDTH-1:0]       din,
  input  logic                   r_en,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = sfifo_addr_w(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);

  if (!sfifo_cfg_ok(WIDTH, DEPTH, FWFT, AF_THRESH, AE_THRESH)) begin : g_bad_cfg
    $error("sfifo_flex: illegal WIDTH/DEPTH/FWFT/threshold configuration");
  end

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] dout_q;
  logic             ovf_q, udf_q;
  logic             rd_acc, wr_acc;

  // Flags come only from the registered pointers; the extra MSB separates full from empty.
  assign count        = wr_ptr - rd_ptr;
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A read at full frees the slot the concurrent write lands in.
  assign rd_acc = r_en && !empty;
  assign wr_acc = w_en && (!full || rd_acc);

  sfifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (din),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout_q <= rdata;
      end
      ovf_q <= w_en && !wr_acc;
      udf_q <= r_en && empty;
    end
  end

  // In FWFT mode dout_q doubles as the "last word read" shown while empty.
  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign dout = empty ? dout_q : rdata;
  end else begin : g_std
    assign dout = dout_q;
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_sfifo_flex.sv
// tb/tb_sfifo_flex.sv - directed table-driven bench for sfifo_flex
module tb_sfifo_flex;

  logic       clk = 1'b0;
  logic       rst;
  logic       w_en, r_en;
  logic [7:0] din;

  logic [7:0] s_dout, f_dout;
  logic [2:0] s_count, f_count;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;

  always #5 clk = ~clk;

  sfifo_flex #(.WIDTH(8), .DEPTH(4), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)) u_std (
    .clk(clk), .rst(rst), .w_en(w_en), .din(din), .r_en(r_en), .dout(s_dout),
    .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .count(s_count), .overflow(s_ovf), .underflow(s_udf)
  );

  sfifo_flex #(.WIDTH(8), .DEPTH(4), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)) u_fwft (
    .clk(clk), .rst(rst), .w_en(w_en), .din(din), .r_en(r_en), .dout(f_dout),
    .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_count), .overflow(f_ovf), .underflow(f_udf)
  );

  typedef struct {
    logic       w, r;
    logic [7:0] din;
    logic [7:0] dout;
    logic [2:0] cnt;
    logic       f, e, af, ae, o, u;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic w, input logic r, input logic [7:0] d, input logic [7:0] q,
                     input logic [2:0] c, input logic f, input logic e, input logic af,
                     input logic ae, input logic o, input logic u);
    vec_t v;
    v.w = w; v.r = r; v.din = d; v.dout = q; v.cnt = c;
    v.f = f; v.e = e; v.af = af; v.ae = ae; v.o = o; v.u = u;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input logic w, input logic r, input logic [7:0] d);
    w_en = w; r_en = r; din = d;
    @(posedge clk);
    #1;
  endtask

  // Packed std-instance view: {dout, count, full, empty, af, ae, ovf, udf}
  function automatic logic [31:0] s_pack();
    return {15'd0, s_dout, s_count, s_full, s_empty, s_af, s_ae, s_ovf, s_udf};
  endfunction

  function automatic logic [31:0] e_pack(input logic [7:0] q, input logic [2:0] c, input logic f,
                                         input logic e, input logic af, input logic ae,
                                         input logic o, input logic u);
    return {15'd0, q, c, f, e, af, ae, o, u};
  endfunction

  initial begin
    //  w  r  din    dout   cnt   f  e  af ae o  u
    add(1, 0, 8'h75, 8'h00, 3'd1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 8'h76, 8'h00, 3'd2, 0, 0, 0, 0, 0, 0);
    add(1, 0, 8'h77, 8'h00, 3'd3, 0, 0, 1, 0, 0, 0);
    add(0, 1, 8'h00, 8'h75, 3'd2, 0, 0, 0, 0, 0, 0);
    add(0, 1, 8'h00, 8'h76, 3'd1, 0, 0, 0, 1, 0, 0);
    add(0, 1, 8'h00, 8'h77, 3'd0, 0, 1, 0, 1, 0, 0);
    add(0, 1, 8'h00, 8'h77, 3'd0, 0, 1, 0, 1, 0, 1);
    add(0, 1, 8'h00, 8'h77, 3'd0, 0, 1, 0, 1, 0, 1);
    add(0, 0, 8'h00, 8'h77, 3'd0, 0, 1, 0, 1, 0, 0);
    add(1, 0, 8'h75, 8'h77, 3'd1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 8'h76, 8'h77, 3'd2, 0, 0, 0, 0, 0, 0);
    add(1, 0, 8'h77, 8'h77, 3'd3, 0, 0, 1, 0, 0, 0);
    add(1, 0, 8'h78, 8'h77, 3'd4, 1, 0, 1, 0, 0, 0);
    add(1, 0, 8'h79, 8'h77, 3'd4, 1, 0, 1, 0, 1, 0);
    add(1, 0, 8'h7A, 8'h77, 3'd4, 1, 0, 1, 0, 1, 0);
    add(1, 1, 8'hA0, 8'h75, 3'd4, 1, 0, 1, 0, 0, 0);
    add(0, 1, 8'h00, 8'h76, 3'd3, 0, 0, 1, 0, 0, 0);
    add(0, 1, 8'h00, 8'h77, 3'd2, 0, 0, 0, 0, 0, 0);
    add(0, 1, 8'h00, 8'h78, 3'd1, 0, 0, 0, 1, 0, 0);
    add(0, 1, 8'h00, 8'hA0, 3'd0, 0, 1, 0, 1, 0, 0);
    add(1, 1, 8'h55, 8'hA0, 3'd1, 0, 0, 0, 1, 0, 1);
    add(0, 1, 8'h00, 8'h55, 3'd0, 0, 1, 0, 1, 0, 0);

    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; din = 8'h00;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_std", s_pack(), e_pack(8'h00, 3'd0, 0, 1, 0, 1, 0, 0));
    check("reset_fwft", {23'd0, f_dout, f_empty}, {23'd0, 8'h00, 1'b1});
    rst = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].w, vq[i].r, vq[i].din);
      check($sformatf("vec%0d", i), s_pack(),
            e_pack(vq[i].dout, vq[i].cnt, vq[i].f, vq[i].e, vq[i].af, vq[i].ae, vq[i].o, vq[i].u));
    end

    // Wrap-around across pointer rollover
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, 8'(k));
      check($sformatf("wrap_wr%0d", k), {28'd0, s_count, s_full}, {28'd0, 3'd1, 1'b0});
      step(1'b0, 1'b1, 8'h00);
      check($sformatf("wrap_rd%0d", k), {20'd0, s_dout, s_count, s_full}, {20'd0, 8'(k), 3'd0, 1'b0});
    end

    // Asynchronous reset mid-cycle with three words stored
    step(1'b1, 1'b0, 8'h31);
    step(1'b1, 1'b0, 8'h32);
    step(1'b1, 1'b0, 8'h33);
    check("pre_rst_count", {29'd0, s_count}, 32'd3);
    w_en = 1'b0;
    #3 rst = 1'b0;
    #1;
    check("async_rst_std", s_pack(), e_pack(8'h00, 3'd0, 0, 1, 0, 1, 0, 0));
    check("async_rst_fwft", {20'd0, f_dout, f_count, f_empty}, {20'd0, 8'h00, 3'd0, 1'b1});
    @(posedge clk);
    #1 rst = 1'b1;
    step(1'b0, 1'b1, 8'h00);
    check("udf_after_rst", s_pack(), e_pack(8'h00, 3'd0, 0, 1, 0, 1, 0, 1));
    step(1'b1, 1'b0, 8'h11);
    check("post_rst_wr", {29'd0, s_count}, 32'd1);
    step(1'b0, 1'b1, 8'h00);
    check("post_rst_rd", {21'd0, s_dout, s_count}, {21'd0, 8'h11, 3'd0});

    // FWFT instance: last-word hold, fall-through, read+write
    check("fwft_hold", {23'd0, f_dout, f_empty}, {23'd0, 8'h11, 1'b1});
    step(1'b1, 1'b0, 8'h5A);
    check("fwft_fall", {20'd0, f_dout, f_count, f_empty}, {20'd0, 8'h5A, 3'd1, 1'b0});
    step(1'b1, 1'b1, 8'h5B);
    check("fwft_rw", {20'd0, f_dout, f_count, f_empty}, {20'd0, 8'h5B, 3'd1, 1'b0});
    step(1'b0, 1'b1, 8'h00);
    check("fwft_drain", {20'd0, f_dout, f_count, f_empty}, {20'd0, 8'h5B, 3'd0, 1'b1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
